instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the instruction decoder: packs RISC-V RV32I fields (format, opcode, regs, functs, imm) into 32-bit words.
//  Streams encoded words into instruction memory through a write port, so test programs and boot code can be loaded in-system.
//  Valid/ready input, one output register honouring memory backpressure, and a load-session FSM with address counter.
// PARAMETERS
//  ADDR_W     10   word-address width of instruction memory; the address wraps at 2**ADDR_W
//  BASE_ADDR  0    first word address written after start
// PORTS
//  clk        in   1       single clock; all state updates on the rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       one-cycle pulse that opens a load session; ignored unless the FSM is in IDLE
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       bundle accepted on a cycle where in_valid && in_ready
//  in_fmt     in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal
//  in_opcode  in   7       opcode[6:0]
//  in_rd      in   5       destination register
//  in_rs1     in   5       source register 1
//  in_rs2     in   5       source register 2
//  in_funct3  in   3       funct3
//  in_funct7  in   7       funct7 (R format only)
//  in_imm     in   32      immediate as a signed byte offset (U format: full upper value)
//  in_last    in   1       marks the final bundle of the session
//  mem_we     out  1       write request; equals the output-register valid bit
//  mem_ready  in   1       memory accepts the write on a cycle where mem_we && mem_ready
//  mem_addr   out  ADDR_W  word address of the pending write
//  mem_wdata  out  32      encoded instruction
//  busy       out  1       FSM is not in IDLE
//  done       out  1       one-cycle pulse after the last word is written
//  count      out  ADDR_W+1  words written this session
//  err        out  3       sticky error flags: [0] illegal fmt, [1] imm range, [2] address wrap
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready, mem_we, busy and done = 0; mem_addr=BASE_ADDR; mem_wdata, count and err = 0.
//   Reset mid-session discards any pending word; nothing is written on the reset cycle.
//  FSM states IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: start moves to RUN and clears count, err and mem_addr (to BASE_ADDR).
//   RUN: in_ready = !mem_we || mem_ready. An accepted bundle with in_last=1 moves to DRAIN.
//   DRAIN: in_ready=0. Waits until the final write is accepted, then moves to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE.
//  Latency: a bundle accepted at cycle N appears with mem_we=1 at N+1. Throughput is 1 word/cycle while mem_ready=1.
//  Writes: mem_we, mem_addr and mem_wdata hold stable until accepted. Same-cycle accept of a new bundle and write of the old one is allowed.
//  On each accepted write, mem_addr increments modulo 2**ADDR_W and count increments.
//   If mem_addr wraps from all-ones to 0, err[2] is set and writing continues.
//  Packing (bits [6:0] always take in_opcode):
//   R: f7 | rs2 | rs1 | f3 | rd.   I: imm[11:0] | rs1 | f3 | rd.   S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0].
//   B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11].   U: imm[31:12] | rd.
//   J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
//  Illegal fmt: the word is replaced by NOP 0x00000013, err[0] is set, and the word is still written.
//  A start pulse while busy is ignored. In IDLE, in_ready=0.
// CONFIGURATION
//  Macro ENC_IMM_CHECK_EN.
//   Defined: err[1] is set when an immediate does not fit its format, and the truncated word is still written. Rules:
//    I/S must fit signed 12 bits; B must fit signed 13 bits and be even; J must fit signed 21 bits and be even; U must have imm[11:0]=0.
//   Undefined: no range check; immediates are silently truncated and err[1] is tied to 0.
// STRUCTURE
//  Package riscv_enc_pkg: format code localparams, RV32I opcode constants, NOP word, err bit indices.
//  Sub-module instr_field_pack: purely combinational packer plus range check (fields in -> word, fmt_err, imm_err out).
//   The top level holds the FSM, output register, address counter and error flags.
// TESTING
//  I, rd=1, rs1=0, f3=0, op=0x13, imm=5 -> mem_wdata 0x00500093 at BASE_ADDR, one cycle after accept.
//  R add x3,x1,x2, then S sw x2,8(x1) back-to-back -> 0x002081B3, then 0x0020A423 at consecutive addresses.
//  B beq x0,x0,imm=-4; J jal x1,8; U lui x5,0x12345000 -> 0xFE000EE3, 0x008000EF, 0x123452B7.
//  mem_ready held 0 for 3 cycles mid-stream -> mem_addr/mem_wdata stable, in_ready=0, no word lost or duplicated.
//  in_fmt=7 -> NOP written and err[0]=1. With the macro defined: I imm=4096 -> err[1]=1; B imm=3 -> err[1]=1.
//  ADDR_W=2 with 5 words, last flagged -> address wrap sets err[2]; count=5 and done pulses once. rst mid-run -> IDLE and all outputs 0.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoder types: format codes, opcodes, NOP word, error flag indices, field bundle.
package riscv_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int ERR_FMT  = 0;
  localparam int ERR_IMM  = 1;
  localparam int ERR_WRAP = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // True when v is representable as a signed value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == 32'sd0) || (s == -32'sd1);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I packer: field bundle -> 32-bit word, plus illegal-format and immediate-range flags.
// Immediate range checking is compiled in with ENC_IMM_CHECK_EN; otherwise imm_err is constant 0.
module instr_field_pack
  import riscv_enc_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        fmt_err,
  output logic        imm_err
);

  always_comb begin
    word    = NOP_WORD;
    fmt_err = 1'b0;
    imm_err = 1'b0;
    case (f.fmt)
      FMT_R: word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I: word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S: word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B: word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3, f.imm[4:1], f.imm[11], f.opcode};
      FMT_U: word = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: begin
        word    = NOP_WORD;
        fmt_err = 1'b1;
      end
    endcase
`ifdef ENC_IMM_CHECK_EN
    case (f.fmt)
      FMT_I, FMT_S: imm_err = !fits_signed(f.imm, 12);
      FMT_B:        imm_err = !fits_signed(f.imm, 13) || f.imm[0];
      FMT_J:        imm_err = !fits_signed(f.imm, 21) || f.imm[0];
      FMT_U:        imm_err = |f.imm[11:0];
      default:      imm_err = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// Load-session encoder: accepted bundle is packed and written to instruction memory one cycle later.
// One output register stalls on mem_ready (in_ready drops); optional ENC_IMM_CHECK_EN adds imm range flag.
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [2:0]        err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [2:0]          err_q, err_d;

  fields_t     fields;
  logic [31:0] packed_word;
  logic        fmt_err, imm_err;
  logic        accept, write;

  assign fields = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  instr_field_pack u_pack (
    .f       (fields),
    .word    (packed_word),
    .fmt_err (fmt_err),
    .imm_err (imm_err)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    write       = mem_we_q && mem_ready;

    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_RUN;
        count_d    = '0;
        err_d      = '0;
        mem_addr_d = BASE;
      end
      ST_RUN:   in_ready = !mem_we_q || mem_ready;
      ST_DRAIN: if (write || !mem_we_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    accept = in_valid && in_ready;

    if (write) begin
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q + 1'b1;
      count_d    = count_q + 1'b1;
      if (&mem_addr_q) err_d[ERR_WRAP] = 1'b1;
    end
    // A new accept refills the register in the same cycle the old word leaves.
    if (accept) begin
      mem_we_d        = 1'b1;
      mem_wdata_d     = packed_word;
      err_d[ERR_FMT]  = err_d[ERR_FMT] | fmt_err;
      err_d[ERR_IMM]  = err_d[ERR_IMM] | imm_err;
      if (in_last) state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed spec vectors, backpressure, mid-run reset, random sessions, address wrap.
module tb_instr_encoder;
  import riscv_enc_pkg::*;

  localparam int AW     = 10;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, mem_ready = 1'b1;
  logic          in_ready, mem_we, busy, done;
  logic [2:0]    in_fmt = '0, in_funct3 = '0;
  logic [6:0]    in_opcode = '0, in_funct7 = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic [2:0]    err;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bun_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  int            n_vec = 0, n_err = 0, done_cnt = 0, exp_addr = 0;
  logic [2:0]    exp_err = '0;
  bit            rdy_rand = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0;
  wr_t           got_wr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoding built by placing each field at its bit offset arithmetically.
  function automatic logic [31:0] model(input bun_t b, output logic bad_fmt, output logic bad_imm);
    logic [31:0] w, im, rd, rs1, rs2, f3;
    im  = b.imm;
    rd  = 32'(b.rd) << 7;
    rs1 = 32'(b.rs1) << 15;
    rs2 = 32'(b.rs2) << 20;
    f3  = 32'(b.f3) << 12;
    w   = 32'(b.op);
    bad_fmt = (b.fmt > 3'd5);
    bad_imm = 1'b0;
    case (b.fmt)
      3'd0: w = w | (32'(b.f7) << 25) | rs2 | rs1 | f3 | rd;
      3'd1: w = w | ((im % 4096) << 20) | rs1 | f3 | rd;
      3'd2: w = w | (((im / 32) % 128) << 25) | rs2 | rs1 | f3 | ((im % 32) << 7);
      3'd3: w = w | (((im / 4096) % 2) << 31) | (((im / 32) % 64) << 25) | rs2 | rs1 | f3
                  | (((im / 2) % 16) << 8) | (((im / 2048) % 2) << 7);
      3'd4: w = w | ((im / 4096) << 12) | rd;
      3'd5: w = w | (((im / 1048576) % 2) << 31) | (((im / 2) % 1024) << 21)
                  | (((im / 2048) % 2) << 20) | (((im / 4096) % 256) << 12) | rd;
      default: w = 32'h0000_0013;
    endcase
`ifdef ENC_IMM_CHECK_EN
    begin
      int s;
      s = $signed(im);
      case (b.fmt)
        3'd1, 3'd2: bad_imm = (s < -2048) || (s > 2047);
        3'd3:       bad_imm = (s < -4096) || (s > 4095) || im[0];
        3'd5:       bad_imm = (s < -1048576) || (s > 1048575) || im[0];
        3'd4:       bad_imm = (im % 4096) != 0;
        default:    bad_imm = 1'b0;
      endcase
    end
`endif
    return w;
  endfunction

  function automatic bun_t mk(input int fmt, input logic [6:0] op, input int rd, input int rs1,
                              input int rs2, input int f3, input int f7, input int imm);
    bun_t b;
    b.fmt = 3'(fmt); b.op = op; b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
    b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = 32'(imm);
    return b;
  endfunction

  function automatic bun_t rand_bun();
    bun_t b;
    int   r;
    r = $urandom_range(0, 15);
    b.fmt = (r < 14) ? 3'(r % 6) : 3'(6 + r % 2);
    b.op  = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom); b.f7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0:       b.imm = $urandom;
      1:       b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       b.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hffff_fffe;
      default: b.imm = $urandom & 32'hffff_f000;
    endcase
    return b;
  endfunction

  // Present one bundle until accepted; the expected write is queued at the accepting edge.
  task automatic send(input bun_t b, input bit last, input bit use_const, input logic [31:0] cw);
    logic        bf, bi;
    logic [31:0] mw;
    bit          ok, r;
    ok = 1'b0;
    mw = model(b, bf, bi);
    in_fmt = b.fmt; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
    in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp_q.push_back(wr_t'{addr: AW'(exp_addr), data: use_const ? cw : mw});
      exp_addr++;
      exp_err[0] = exp_err[0] | bf;
      exp_err[1] = exp_err[1] | bi;
      if (exp_addr >= NWORDS) exp_err[2] = 1'b1;
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready never high, required within 2000 cycles");
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_addr = 0;
    exp_err  = '0;
    done_cnt = 0;
  endtask

  task automatic end_session(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_done_timeout: done never pulsed, required within 3000 cycles", tag);
    end else begin
      chk({tag, "_count"}, count, exp_addr);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_busy_in_done"}, busy, 1);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_busy_idle"}, busy, 0);
    end
    @(posedge clk);
    #1;
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic rand_session(input int n, input bit poke_start);
    for (int i = 0; i < n; i++) begin
      if (poke_start && i == n / 2) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      send(rand_bun(), i == n - 1, 1'b0, 32'h0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) mem_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every accepted write, checks stall stability and in_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold) chk("hold_stable", {mem_we, mem_addr, mem_wdata}, {1'b1, prev_addr, prev_data});
        if (mem_we && !mem_ready) chk("stall_in_ready", in_ready, 0);
        if (!busy) chk("idle_in_ready", in_ready, 0);
        if (mem_we && mem_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected_write: addr %h data %h, none expected", mem_addr, mem_wdata);
          end else begin
            got_wr = exp_q.pop_front();
            chk("wr_addr", mem_addr, got_wr.addr);
            chk("wr_data", mem_wdata, got_wr.data);
          end
        end
        if (done) done_cnt++;
      end
      hold      = mem_we && !mem_ready && !rst;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {in_ready, mem_we, busy, done, mem_addr, mem_wdata, count, err}, 0);
    @(posedge clk);
    #1;

    begin_session();
    send(mk(1, OP_IMM, 1, 0, 0, 0, 0, 5), 1'b1, 1'b1, 32'h0050_0093);
    @(negedge clk);
    chk("latency_we", mem_we, 1);
    chk("latency_addr", mem_addr, 0);
    chk("latency_data", mem_wdata, 32'h0050_0093);
    end_session("addi");

    begin_session();
    send(mk(0, OP_REG, 3, 1, 2, 0, 0, 0), 1'b0, 1'b1, 32'h0020_81B3);
    send(mk(2, OP_STORE, 0, 1, 2, 2, 0, 8), 1'b0, 1'b1, 32'h0020_A423);
    send(mk(3, OP_BRANCH, 0, 0, 0, 0, 0, -4), 1'b0, 1'b1, 32'hFE00_0EE3);
    send(mk(5, OP_JAL, 1, 0, 0, 0, 0, 8), 1'b0, 1'b1, 32'h0080_00EF);
    send(mk(4, OP_LUI, 5, 0, 0, 0, 0, 32'h1234_5000), 1'b0, 1'b1, 32'h1234_52B7);
    send(mk(7, OP_IMM, 1, 2, 3, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0013);
    send(mk(1, OP_IMM, 1, 0, 0, 0, 0, 4096), 1'b0, 1'b1, 32'h0000_0093);
    send(mk(3, OP_BRANCH, 0, 0, 0, 0, 0, 3), 1'b1, 1'b1, 32'h0000_0163);
    end_session("formats");

    begin_session();
    send(mk(1, OP_IMM, 1, 1, 0, 0, 0, 1), 1'b0, 1'b1, 32'h0010_8093);
    send(mk(1, OP_IMM, 2, 2, 0, 0, 0, 2), 1'b0, 1'b1, 32'h0021_0113);
    mem_ready = 1'b0;
    fork
      send(mk(1, OP_IMM, 3, 3, 0, 0, 0, 3), 1'b0, 1'b1, 32'h0031_8193);
      begin
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
    join
    send(mk(1, OP_IMM, 4, 4, 0, 0, 0, 4), 1'b1, 1'b1, 32'h0042_0213);
    end_session("stall");

    mem_ready = 1'b0;
    begin_session();
    send(mk(6, OP_IMM, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h0000_0013);
    @(negedge clk);
    chk("pre_reset_err", err, 3'b001);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_reset_state", {in_ready, mem_we, busy, done, mem_addr, mem_wdata, count, err}, 0);
    @(posedge clk);
    #1 mem_ready = 1'b1;

    rdy_rand = 1'b1;
    for (int s = 0; s < 3; s++) begin
      begin_session();
      rand_session(20 + 10 * s, s != 1);
      end_session("random");
    end
    begin_session();
    rand_session(NWORDS + 6, 1'b0);
    end_session("wrap");
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
